// File: rtl/preadder_pkg.sv
// Shared constants and helpers for the A/D pre-adder stage: INMODE bit map,
// valid-line latency and the wrap/clamp step applied to the M_W+1 bit sum.
package preadder_pkg;

  localparam int IM_ASEL  = 0;
  localparam int IM_AZERO = 1;
  localparam int IM_DEN   = 2;
  localparam int IM_SUB   = 3;

  function automatic int calc_lat(input int areg, input int dreg, input int adreg,
                                  input bit use_d);
    if (use_d) return ((areg > dreg) ? areg : dreg) + adreg;
    return areg;
  endfunction

  // sum holds the M_W+1 bit result sign-extended to 64 bits; mw is M_W.
  function automatic logic [63:0] sat_trunc(input logic [63:0] sum, input int mw,
                                            input bit sat_en);
    logic [63:0] min_v;
    min_v = {64{1'b1}} << (mw - 1);
    if (sat_en && (sum[mw] != sum[mw-1])) return sum[mw] ? min_v : ~min_v;
    return sum;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Async-reset register with clock enable; one cycle latency when ce_i is high,
// holds its value when ce_i is low.
module pipe_reg #(
  parameter int N = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ce_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     data_q <= '0;
    else if (ce_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/preadder_pipe_ad.sv
// A/ACIN/D input pipeline and pre-adder feeding the multiplier; latency LAT=calc_lat().
// No backpressure, CEs only freeze data stages; PREADD_SAT_EN selects clamp instead of wrap.
module preadder_pipe_ad
  import preadder_pkg::*;
#(
  parameter int    A_W       = 30,
  parameter int    D_W       = 25,
  parameter int    M_W       = 25,
  parameter string A_INPUT   = "DIRECT",
  parameter int    AREG      = 2,
  parameter int    ACASCREG  = 1,
  parameter int    DREG      = 1,
  parameter int    ADREG     = 1,
  parameter int    INMODEREG = 1,
  parameter string USE_DPORT = "TRUE"
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [A_W-1:0] A,
  input  logic [A_W-1:0] ACIN,
  input  logic [D_W-1:0] D,
  input  logic [3:0]     INMODE,
  input  logic           CEA1,
  input  logic           CEA2,
  input  logic           CED,
  input  logic           CEAD,
  input  logic           CEINMODE,
  input  logic           VALID_IN,
  output logic [M_W-1:0] A_MULT,
  output logic [A_W-1:0] ACOUT,
  output logic [A_W-1:0] X_MUX_A,
  output logic           OVF,
  output logic           VALID_OUT
);

  localparam bit USE_D  = (USE_DPORT == "TRUE");
  localparam bit CASC   = (A_INPUT == "CASCADE");
  localparam int LAT    = calc_lat(AREG, DREG, ADREG, USE_D);
`ifdef PREADD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [A_W-1:0] a1_in, a1, a2;
  logic [3:0]     inm;
  logic [M_W-1:0] aop;

  assign a1_in = CASC ? ACIN : A;

  generate
    if (AREG == 2) begin : g_areg2
      pipe_reg #(.N(A_W)) u_a1 (.clk_i(CLK), .rst_i(RST), .ce_i(CEA1), .d_i(a1_in), .q_o(a1));
      pipe_reg #(.N(A_W)) u_a2 (.clk_i(CLK), .rst_i(RST), .ce_i(CEA2), .d_i(a1),    .q_o(a2));
    end else if (AREG == 1) begin : g_areg1
      pipe_reg #(.N(A_W)) u_a1 (.clk_i(CLK), .rst_i(RST), .ce_i(CEA1), .d_i(a1_in), .q_o(a1));
      assign a2 = a1;
    end else begin : g_areg0
      assign a1 = a1_in;
      assign a2 = a1_in;
    end

    if (ACASCREG == 2)      begin : g_acout2 assign ACOUT = a2;    end
    else if (ACASCREG == 1) begin : g_acout1 assign ACOUT = a1;    end
    else                    begin : g_acout0 assign ACOUT = a1_in; end

    if (INMODEREG == 1) begin : g_inmreg
      pipe_reg #(.N(4)) u_inm (.clk_i(CLK), .rst_i(RST), .ce_i(CEINMODE), .d_i(INMODE), .q_o(inm));
    end else begin : g_inmdir
      assign inm = INMODE;
    end
  endgenerate

  assign X_MUX_A = a2;
  // A1 select lets the A operand skip the A2 stage.
  assign aop = inm[IM_AZERO] ? '0 : (inm[IM_ASEL] ? a1[M_W-1:0] : a2[M_W-1:0]);

  generate
    if (USE_D) begin : g_dport
      logic [D_W-1:0]        d_r;
      logic [M_W-1:0]        dop, res_c;
      logic signed [M_W:0]   aop_x, dop_x, sum_w;
      logic [63:0]           sat_full;
      logic                  ovf_c;
      logic                  unused_sat;

      if (DREG == 1) begin : g_dreg
        pipe_reg #(.N(D_W)) u_d (.clk_i(CLK), .rst_i(RST), .ce_i(CED), .d_i(D), .q_o(d_r));
      end else begin : g_ddir
        assign d_r = D;
      end

      assign dop      = inm[IM_DEN] ? M_W'($signed(d_r)) : '0;
      assign aop_x    = (M_W+1)'($signed(aop));
      assign dop_x    = (M_W+1)'($signed(dop));
      assign sum_w    = inm[IM_SUB] ? (dop_x - aop_x) : (dop_x + aop_x);
      assign ovf_c    = sum_w[M_W] ^ sum_w[M_W-1];
      assign sat_full = sat_trunc(64'(sum_w), M_W, SAT_EN);
      assign res_c    = sat_full[M_W-1:0];
      assign unused_sat = ^sat_full[63:M_W];

      if (ADREG == 1) begin : g_adreg
        logic [M_W:0] ad_q;
        pipe_reg #(.N(M_W+1)) u_ad (.clk_i(CLK), .rst_i(RST), .ce_i(CEAD),
                                    .d_i({ovf_c, res_c}), .q_o(ad_q));
        assign A_MULT = ad_q[M_W-1:0];
        assign OVF    = ad_q[M_W];
      end else begin : g_addir
        assign A_MULT = res_c;
        assign OVF    = ovf_c;
      end
    end else begin : g_nodport
      assign A_MULT = aop;
      assign OVF    = 1'b0;
    end

    if (LAT == 0) begin : g_vld0
      assign VALID_OUT = VALID_IN;
    end else begin : g_vld
      logic [LAT:0] vld_chain;
      assign vld_chain[0] = VALID_IN;
      for (genvar i = 0; i < LAT; i++) begin : g_stage
        pipe_reg #(.N(1)) u_v (.clk_i(CLK), .rst_i(RST), .ce_i(1'b1),
                               .d_i(vld_chain[i]), .q_o(vld_chain[i+1]));
      end
      assign VALID_OUT = vld_chain[LAT];
    end
  endgenerate

  // Some inputs are dead in particular parameterisations.
  logic unused_inputs;
  assign unused_inputs = ^{A, ACIN, D, INMODE, inm, CEA1, CEA2, CED, CEAD, CEINMODE};

endmodule

// File: tb/tb_preadder_pipe_ad.sv
// Directed bench: default instance (LAT=3), cascade/CE instance and a no-D-port instance.
module tb_preadder_pipe_ad;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [29:0] A = '0, c_acin = '0;
  logic [24:0] D = '0;
  logic [3:0]  INMODE = '0;
  logic        CEA1 = 1'b1, CEA2 = 1'b1, CED = 1'b1, CEAD = 1'b1, CEINMODE = 1'b1;
  logic        c_cea2 = 1'b0;
  logic        VALID_IN = 1'b0;

  logic [24:0] A_MULT, c_amult, n_amult;
  logic [29:0] ACOUT, X_MUX_A, c_acout, c_xmux, n_acout, n_xmux;
  logic        OVF, VALID_OUT, c_ovf, c_vld, n_ovf, n_vld;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  preadder_pipe_ad dut (
    .CLK(CLK), .RST(RST), .A(A), .ACIN(c_acin), .D(D), .INMODE(INMODE),
    .CEA1(CEA1), .CEA2(CEA2), .CED(CED), .CEAD(CEAD), .CEINMODE(CEINMODE),
    .VALID_IN(VALID_IN), .A_MULT(A_MULT), .ACOUT(ACOUT), .X_MUX_A(X_MUX_A),
    .OVF(OVF), .VALID_OUT(VALID_OUT)
  );

  preadder_pipe_ad #(.A_INPUT("CASCADE"), .AREG(2), .ACASCREG(1)) u_casc (
    .CLK(CLK), .RST(RST), .A(A), .ACIN(c_acin), .D(D), .INMODE(INMODE),
    .CEA1(CEA1), .CEA2(c_cea2), .CED(CED), .CEAD(CEAD), .CEINMODE(CEINMODE),
    .VALID_IN(VALID_IN), .A_MULT(c_amult), .ACOUT(c_acout), .X_MUX_A(c_xmux),
    .OVF(c_ovf), .VALID_OUT(c_vld)
  );

  preadder_pipe_ad #(.USE_DPORT("FALSE")) u_nod (
    .CLK(CLK), .RST(RST), .A(A), .ACIN(c_acin), .D(D), .INMODE(INMODE),
    .CEA1(CEA1), .CEA2(CEA2), .CED(CED), .CEAD(CEAD), .CEINMODE(CEINMODE),
    .VALID_IN(VALID_IN), .A_MULT(n_amult), .ACOUT(n_acout), .X_MUX_A(n_xmux),
    .OVF(n_ovf), .VALID_OUT(n_vld)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle VALID pulse with data held; checked when VALID_OUT should rise (3 edges).
  task automatic run_vec(input string tag, input logic [29:0] a, input logic [24:0] d,
                         input logic [3:0] inm, input logic [24:0] exp_mult,
                         input logic exp_ovf);
    @(negedge CLK);
    A = a; D = d; INMODE = inm; VALID_IN = 1'b1;
    @(posedge CLK); #1 VALID_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk({tag, "_vld"},  64'(VALID_OUT), 64'd1);
    chk({tag, "_mult"}, 64'(A_MULT),    64'(exp_mult));
    chk({tag, "_ovf"},  64'(OVF),       64'(exp_ovf));
    @(posedge CLK); #1;
    chk({tag, "_vld_off"}, 64'(VALID_OUT), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat_seen;
    // Reset state
    #12;
    chk("rst_mult",  64'(A_MULT),    64'd0);
    chk("rst_acout", 64'(ACOUT),     64'd0);
    chk("rst_xmux",  64'(X_MUX_A),   64'd0);
    chk("rst_ovf",   64'(OVF),       64'd0);
    chk("rst_vld",   64'(VALID_OUT), 64'd0);
    @(negedge CLK); RST = 1'b0;

    run_vec("add",   30'd5,  25'd7, 4'b0100, 25'd12, 1'b0);
    run_vec("sub",   30'd10, 25'd3, 4'b1100, 25'(-7), 1'b0);
    run_vec("donly", 30'd9,  25'd77, 4'b0110, 25'd77, 1'b0);
    run_vec("zero",  30'd9,  25'd77, 4'b0010, 25'd0, 1'b0);
    run_vec("alow",  30'h2123_4567, 25'd77, 4'b0000, 25'h123_4567, 1'b0);
    chk("alow_xmux", 64'(X_MUX_A), 64'h2123_4567);
    chk("alow_acout", 64'(ACOUT), 64'h2123_4567);
`ifdef PREADD_SAT_EN
    run_vec("ovf_pos", 30'd1, 25'hFF_FFFF,  4'b0100, 25'hFF_FFFF,  1'b1);
    run_vec("ovf_neg", 30'd1, 25'h100_0000, 4'b1100, 25'h100_0000, 1'b1);
`else
    run_vec("ovf_pos", 30'd1, 25'hFF_FFFF,  4'b0100, 25'h100_0000, 1'b1);
    run_vec("ovf_neg", 30'd1, 25'h100_0000, 4'b1100, 25'hFF_FFFF,  1'b1);
`endif

    // No D port: A2 low bits, OVF held low, LAT=2
    @(negedge CLK);
    A = 30'h3E00_0ABC; D = 25'd7; INMODE = 4'b1100; VALID_IN = 1'b1;
    @(posedge CLK); #1 VALID_IN = 1'b0;
    @(posedge CLK); #1;
    chk("nod_vld",  64'(n_vld),   64'd1);
    chk("nod_mult", 64'(n_amult), 64'h0ABC);
    chk("nod_ovf",  64'(n_ovf),   64'd0);

    // Cascade with CEA2 low: ACOUT follows ACIN through A1, X_MUX_A stays frozen
    @(negedge CLK); c_acin = 30'h0123_4567;
    #1 chk("casc_pre", 64'(c_acout), 64'd0);
    @(posedge CLK); #1;
    chk("casc_acout1", 64'(c_acout), 64'h0123_4567);
    chk("casc_xmux1",  64'(c_xmux),  64'd0);
    @(negedge CLK); c_acin = 30'h2AAA_AAAA;
    #1 chk("casc_hold", 64'(c_acout), 64'h0123_4567);
    @(posedge CLK); #1;
    chk("casc_acout2", 64'(c_acout), 64'h2AAA_AAAA);
    chk("casc_xmux2",  64'(c_xmux),  64'd0);

    // Reset in the middle of a valid stream
    @(negedge CLK);
    A = 30'd5; D = 25'd7; INMODE = 4'b0100; VALID_IN = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK); RST = 1'b1; VALID_IN = 1'b0;
    #1;
    chk("mrst_mult",  64'(A_MULT),    64'd0);
    chk("mrst_acout", 64'(ACOUT),     64'd0);
    chk("mrst_xmux",  64'(X_MUX_A),   64'd0);
    chk("mrst_ovf",   64'(OVF),       64'd0);
    chk("mrst_vld",   64'(VALID_OUT), 64'd0);
    @(negedge CLK); RST = 1'b0;
    repeat (2) @(negedge CLK);
    VALID_IN = 1'b1;
    lat_seen = -1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK); #1;
      VALID_IN = 1'b0;
      if (VALID_OUT && lat_seen < 0) lat_seen = k;
    end
    chk("mrst_lat", 64'(lat_seen), 64'd3);
    chk("mrst_mult_after", 64'(A_MULT), 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
